argmax_sequencer: RTL
=====================

# argmax_sequencer

Controller that sequences the shared argmax engine (`maxFinder`) at the tail of the neural-network datapath. It accepts the output-layer neuron values as a serial valid/ready stream and packs them into the engine's flat input vector. It then launches the engine, waits for its result, and holds the winning class index until the downstream consumer takes it. A 16-bit counter records completed inferences.

## Interface
- `NUM_NEURONS`, 10: number of output-layer values per inference; legal range ≥ 1.
- `DATA_WIDTH`, 16: width of each neuron value. Values are compared as unsigned.
- `CLK`  in  1: single clock; all state changes on its rising edge.
- `RESET`  in  1: asynchronous, active-high reset.
- `i_start`  in  1: begins a new inference. Honoured only in IDLE.
- `s_data`  in  `DATA_WIDTH`: neuron value; its index is its arrival order, starting at 0.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the block accepts `s_data` this cycle.
- `o_class`  out  32: index of the winning neuron.
- `o_class_valid`  out  1: `o_class` is valid.
- `i_class_ready`  in  1: the consumer accepts `o_class`.
- `o_busy`  out  1: high in every state except IDLE.
- `o_infer_count`  out  16: number of results accepted by the consumer; wraps modulo 2^16.

## Operation
- **Reset values:** state IDLE, `s_ready`=0, `o_class`=0, `o_class_valid`=0, `o_busy`=0, `o_infer_count`=0, index counter=0. The packing buffer is also cleared to 0.
- **IDLE:** `s_ready`=0. When `i_start`=1, go to COLLECT and clear the index counter.
- **COLLECT:** `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) writes `s_data` into buffer slot [idx·DATA_WIDTH +: DATA_WIDTH] and increments idx.
  - The handshake with idx==NUM_NEURONS−1 goes to LAUNCH.
- **LAUNCH:** lasts exactly one cycle. Drive the engine's `i_valid`=1 with the buffer on `i_data`, then go to WAIT.
- **WAIT:** on the engine's `o_data_valid`=1, register `o_data` into `o_class` and go to HOLD.
- **HOLD:** `o_class_valid`=1. When `i_class_ready`=1, go to IDLE and increment `o_infer_count`.
- **Tie-break:** the engine uses strict-greater comparison, so the lowest index wins ties.
- **Ignored inputs:** `i_start` outside IDLE has no effect. `s_valid` outside COLLECT is not accepted.
- **Engine output outside WAIT:** the engine has no reset, so `o_data_valid` seen outside WAIT is ignored. This covers a stale pulse left over from a run aborted by `RESET`. A new LAUNCH restarts the engine, and its `i_valid` has priority over any in-flight count.
- **Reset mid-operation:** all state returns to its reset values immediately. A partially collected vector is discarded.

## Timing
- **Input handshake:** `s_ready` depends only on the registered state, not on any input in the same cycle.
- **Start to first acceptance:** `i_start` sampled at edge e leads to the first possible acceptance at edge e+1.
- **Engine launch:**
  - The last sample is accepted at edge e0.
  - LAUNCH occupies the cycle after e0.
  - The engine samples `i_valid` at e0+1.
  - The engine raises `o_data_valid` after e0+1+NUM_NEURONS.
- **Result latency:** `o_class_valid` rises after edge e0+NUM_NEURONS+2. That is 12 edges for the default NUM_NEURONS=10.
- **Output hold:** `o_class` and `o_class_valid` stay stable while `i_class_ready`=0.
- **Output release:** if `i_class_ready`=1 is already high on HOLD entry, HOLD lasts exactly one cycle. `o_class_valid` drops on the next edge.
- **Back-to-back inferences:** `i_start` is honoured in the first IDLE cycle after HOLD. The minimum period is therefore NUM_NEURONS + NUM_NEURONS + 4 cycles.

## Structure
- **Shared package `nn_pkg`:**
  - state enum: IDLE, COLLECT, LAUNCH, WAIT, HOLD;
  - `CLASS_WIDTH`=32;
  - `INFER_COUNT_WIDTH`=16.
- **Sub-modules:** one instance of the existing `maxFinder` (numInput=`NUM_NEURONS`, inputWidth=`DATA_WIDTH`). No other sub-modules.
- **Index counter width:** $clog2(NUM_NEURONS+1).

## Test plan
- **Basic argmax:** values 5,9,3,200,7,1,0,12,199,4 with `i_class_ready` held at 1 → `o_class`=3, `o_class_valid` high exactly 12 edges after the last acceptance, `o_infer_count`=1.
- **Tie:** values with 0x00FF at indices 2 and 6, all others 0x0010 → `o_class`=2.
- **Input gaps and backpressure:** insert random `s_valid` gaps; hold `i_class_ready`=0 for 20 cycles in HOLD → `o_class` stable, no second inference starts, `i_start` ignored. Then raise `i_class_ready` → IDLE on the next edge.
- **Reset mid-operation:** assert `RESET` after 4 samples, then run a full new inference with maximum 0xFFFF at index 9 → `o_class`=9, `o_infer_count`=1, no spurious `o_class_valid`.
- **Counter wrap and inputs in IDLE:** preload via 65536 inferences (or a force) → `o_infer_count` goes 0xFFFF→0x0000. `s_valid`=1 in IDLE is never accepted (`s_ready`=0).

Source files
------------

// File: rtl/argmax_sequencer_pkg.sv
// Shared types and widths for the argmax tail of the NN datapath.
package nn_pkg;

  localparam int CLASS_WIDTH       = 32;
  localparam int INFER_COUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/argmax_sequencer_if.sv
// Neuron-value input stream and class-result output handshake.
interface argmax_sequencer_if
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]  s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [CLASS_WIDTH-1:0] o_class;
  logic                   o_class_valid;
  logic                   i_class_ready;

  // Producer/consumer side (drives samples, accepts results).
  modport master (
    output s_data, s_valid, i_class_ready,
    input  s_ready, o_class, o_class_valid
  );

  // Sequencer side.
  modport slave (
    input  s_data, s_valid, i_class_ready,
    output s_ready, o_class, o_class_valid
  );

endinterface

// File: rtl/argmax_sequencer_max_finder.sv
// Shared argmax engine: scans the flat input vector one element per cycle
// and pulses o_data_valid with the index of the first maximum. No reset.
module maxFinder
  import nn_pkg::*;
#(
  parameter int numInput   = 10,
  parameter int inputWidth = 16
) (
  input  logic                             i_clk,
  input  logic [numInput*inputWidth-1:0]   i_data,
  input  logic                             i_valid,
  output logic [CLASS_WIDTH-1:0]           o_data,
  output logic                             o_data_valid
);

  localparam int CW = $clog2(numInput + 1);

  logic [numInput*inputWidth-1:0] data_q, data_d;
  logic [inputWidth-1:0]          max_q, max_d;
  logic [CW-1:0]                  idx_q, idx_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           run_q, run_d;
  logic [CLASS_WIDTH-1:0]         out_q, out_d;
  logic                           out_valid_q, out_valid_d;
  logic [inputWidth-1:0]          cur;

  // Scan step: a new i_valid always restarts the scan, even mid-run.
  always_comb begin
    data_d      = data_q;
    max_d       = max_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    cur         = data_q[cnt_q*inputWidth +: inputWidth];
    if (i_valid) begin
      data_d = i_data;
      max_d  = i_data[inputWidth-1:0];
      idx_d  = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      // Strict greater-than keeps the lowest index on ties.
      if (cur > max_q) begin
        max_d = cur;
        idx_d = cnt_q;
      end
      if (cnt_q == CW'(numInput - 1)) begin
        run_d       = 1'b0;
        out_valid_d = 1'b1;
        out_d       = CLASS_WIDTH'(idx_d);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Engine registers.
  always_ff @(posedge i_clk) begin
    data_q      <= data_d;
    max_q       <= max_d;
    idx_q       <= idx_d;
    cnt_q       <= cnt_d;
    run_q       <= run_d;
    out_q       <= out_d;
    out_valid_q <= out_valid_d;
  end

  assign o_data       = out_q;
  assign o_data_valid = out_valid_q;

endmodule

// File: rtl/argmax_sequencer.sv
// Collects NUM_NEURONS serial values, runs maxFinder on them and holds the
// winning class index until the consumer takes it; counts accepted results.
module argmax_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         i_start,
  argmax_sequencer_if.slave            bus,
  output logic                         o_busy,
  output logic [INFER_COUNT_WIDTH-1:0] o_infer_count
);

  localparam int IDX_W = $clog2(NUM_NEURONS + 1);
  localparam int BUF_W = NUM_NEURONS * DATA_WIDTH;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [BUF_W-1:0]             buf_q, buf_d;
  logic [CLASS_WIDTH-1:0]       class_q, class_d;
  logic                         class_valid_q, class_valid_d;
  logic                         s_ready_q, s_ready_d;
  logic                         busy_q, busy_d;
  logic                         launch_q, launch_d;
  logic [INFER_COUNT_WIDTH-1:0] infer_count_q, infer_count_d;

  logic                         hs;
  logic [CLASS_WIDTH-1:0]       eng_data;
  logic                         eng_valid;

  assign hs = bus.s_valid & s_ready_q;

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with the state register.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    class_d       = class_q;
    infer_count_d = infer_count_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_COLLECT;
          idx_d   = '0;
        end
      end
      S_COLLECT: begin
        if (hs) begin
          buf_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_NEURONS - 1)) state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // Engine pulses outside WAIT (e.g. stale after reset) are ignored.
        if (eng_valid) begin
          class_d = eng_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.i_class_ready) begin
          state_d       = S_IDLE;
          infer_count_d = infer_count_q + INFER_COUNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    s_ready_d     = (state_d == S_COLLECT);
    busy_d        = (state_d != S_IDLE);
    class_valid_d = (state_d == S_HOLD);
    launch_d      = (state_d == S_LAUNCH);
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      buf_q         <= '0;
      class_q       <= '0;
      class_valid_q <= 1'b0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      launch_q      <= 1'b0;
      infer_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      launch_q      <= launch_d;
      infer_count_q <= infer_count_d;
    end
  end

  maxFinder #(
    .numInput  (NUM_NEURONS),
    .inputWidth(DATA_WIDTH)
  ) u_max_finder (
    .i_clk       (CLK),
    .i_data      (buf_q),
    .i_valid     (launch_q),
    .o_data      (eng_data),
    .o_data_valid(eng_valid)
  );

  assign bus.s_ready       = s_ready_q;
  assign bus.o_class       = class_q;
  assign bus.o_class_valid = class_valid_q;
  assign o_busy            = busy_q;
  assign o_infer_count     = infer_count_q;

endmodule
